// File: rtl/pipeline_ctrl_if.sv
// Stall/flush control bundle between the pipeline (master) and pipeline_ctrl (slave).
// Carries per-stage stall requests in and the merged stall vector, flush and redirect PC out.
interface pipeline_ctrl_if #(
   parameter int STAGES     = 5,
   parameter int ADDR_WIDTH = 32
);
   logic [STAGES-1:0]     stall_req_in;
   logic                  flush_req_in;
   logic [ADDR_WIDTH-1:0] flush_pc_in;
   logic [STAGES-1:0]     stall_out;
   logic                  flush_out;
   logic [ADDR_WIDTH-1:0] flush_pc_out;
   logic                  busy_out;

   modport master (
      output stall_req_in, flush_req_in, flush_pc_in,
      input  stall_out, flush_out, flush_pc_out, busy_out
   );

   modport slave (
      input  stall_req_in, flush_req_in, flush_pc_in,
      output stall_out, flush_out, flush_pc_out, busy_out
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline stall merge and exception/eret flush sequencer; PIPE_CTRL_PERF_EN adds perf counters.
// Latency: stall_out combinational; flush_out/flush_pc_out one cycle after flush_req_in, held 1+FLUSH_HOLD cycles.
// Backpressure: a flush is deferred (PENDING) while the last stage holds an uninterruptible stall.
module pipeline_ctrl #(
   parameter int STAGES     = 5,
   parameter int ADDR_WIDTH = 32,
   parameter int FLUSH_HOLD = 1
) (
   input  logic              clk,
   input  logic              rst,
   pipeline_ctrl_if.slave    bus
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]       stall_cycles_out,
   output logic [31:0]       flush_count_out
`endif
);

   typedef enum logic [1:0] {IDLE, PENDING, FLUSH} state_t;

   localparam logic [3:0] HOLD = 4'(FLUSH_HOLD);

   state_t                state;
   logic [3:0]            cnt;
   logic                  flush_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pend_pc;
   logic [STAGES-1:0]     merged;
   logic                  last_stall;
   logic                  enter_flush;

   assign last_stall = bus.stall_req_in[STAGES-1];

   // A stalled stage holds itself and every older (lower-index) stage.
   always_comb begin
      merged = '0;
      for (int i = 0; i < STAGES; i++) begin
         merged[i] = |(bus.stall_req_in >> i);
      end
   end

   assign enter_flush = ((state == IDLE && bus.flush_req_in) || state == PENDING) && !last_stall;

   assign bus.stall_out    = (!rst || flush_q) ? '0 : merged;
   assign bus.flush_out    = flush_q;
   assign bus.flush_pc_out = pc_q;
   assign bus.busy_out     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         flush_q <= 1'b0;
         pc_q    <= '0;
         pend_pc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enter_flush) begin
                  state   <= FLUSH;
                  flush_q <= 1'b1;
                  pc_q    <= bus.flush_pc_in;
                  cnt     <= HOLD;
               end else if (bus.flush_req_in) begin
                  state   <= PENDING;
                  pend_pc <= bus.flush_pc_in;
               end
            end
            PENDING: begin
               if (bus.flush_req_in) begin
                  pend_pc <= bus.flush_pc_in;
               end
               // A request arriving on the release cycle is the latest one and wins.
               if (enter_flush) begin
                  state   <= FLUSH;
                  flush_q <= 1'b1;
                  pc_q    <= bus.flush_req_in ? bus.flush_pc_in : pend_pc;
                  cnt     <= HOLD;
               end
            end
            FLUSH: begin
               if (bus.flush_req_in) begin
                  pc_q <= bus.flush_pc_in;
                  cnt  <= HOLD;
               end else if (cnt == 4'd0) begin
                  state   <= IDLE;
                  flush_q <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state   <= IDLE;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cycles_out <= '0;
         flush_count_out  <= '0;
      end else begin
         if (|bus.stall_out) begin
            stall_cycles_out <= stall_cycles_out + 32'd1;
         end
         if (enter_flush) begin
            flush_count_out <= flush_count_out + 32'd1;
         end
      end
   end
`endif

endmodule
